snn_run_controller: RTL and testbench

Sequencer that runs one inference window of the spiking network. On a start command it clears the network, enables the Bernoulli spike generator for a programmed number of timesteps, drains in-flight spikes, and accumulates per-output spike counts for readback through the AXI configuration registers. It sits in `snn_core_top` between the control/status registers and the `if_network` / `bernoulli_spike_generator` pair. It also locks external memory writes while a run is in progress.

---
 rtl/snn_pkg.sv | 17 +
 rtl/spike_count_sat.sv | 30 +++
 rtl/snn_run_controller.sv | 144 ++++++++++++++
 tb/tb_snn_run_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and default widths for the spiking-network run controller.
//   snn_run_state_t : run sequencer states (IDLE, CLEAR, RUN, DRAIN)
//   SNN_COUNT_WIDTH : default per-output spike counter width
//   SNN_STEP_WIDTH  : default timestep counter width
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } snn_run_state_t;

    localparam int SNN_COUNT_WIDTH = 16;
    localparam int SNN_STEP_WIDTH  = 16;

endpackage

// File: rtl/spike_count_sat.sv
// One saturating up-counter for a single output neuron.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear (takes priority over en)
//   en         : count one spike this cycle
//   count      : current count, holds at all-ones instead of wrapping
module spike_count_sat
    import snn_pkg::*;
#(
    parameter int WIDTH = SNN_COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/snn_run_controller.sv
// Sequencer for one inference window of the spiking network.
//   S_AXI_ACLK, S_AXI_ARESETN : clock, asynchronous active-low reset
//   start, abort              : single-cycle run request / cancel
//   num_steps                 : timesteps per run, latched on accepted start
//   spike_out                 : network output spikes (one bit per output)
//   net_rst                   : network clear request (CLEAR phase)
//   spike_gen_en              : spike generator enable (RUN phase)
//   mem_lock, busy            : high while a run is in progress
//   done                      : sticky, last run completed without abort
//   step_cnt                  : timesteps elapsed in current/last run
//   count_out                 : per-output spike counts, output i at
//                               [i*COUNT_WIDTH +: COUNT_WIDTH]
module snn_run_controller
    import snn_pkg::*;
#(
    parameter int NUM_OUTPUTS   = 1,
    parameter int COUNT_WIDTH   = SNN_COUNT_WIDTH,
    parameter int STEP_WIDTH    = SNN_STEP_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESETN,
    input  logic                               start,
    input  logic                               abort,
    input  logic [STEP_WIDTH-1:0]              num_steps,
    input  logic [NUM_OUTPUTS-1:0]             spike_out,
    output logic                               net_rst,
    output logic                               spike_gen_en,
    output logic                               mem_lock,
    output logic                               busy,
    output logic                               done,
    output logic [STEP_WIDTH-1:0]              step_cnt,
    output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] count_out
);

    localparam int PHASE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SETTLE_CYCLES - 1);

    snn_run_state_t        state, state_next;
    logic [PHASE_W-1:0]    phase_cnt;
    logic [STEP_WIDTH-1:0] steps_lat;
    logic                  accept_start;
    logic                  finish;
    logic                  counting;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        finish       = 1'b0;
        case (state)
            IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    state_next   = CLEAR;
                    accept_start = 1'b1;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (phase_cnt == PHASE_LAST) begin
                    state_next = (steps_lat != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                // step_cnt already counts the current RUN cycle
                if (abort) begin
                    state_next = IDLE;
                end else if (step_cnt == steps_lat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (phase_cnt == PHASE_LAST) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The abort edge itself is not counted so counts freeze where they stand.
    assign counting = ((state == RUN) || (state == DRAIN)) && !abort;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            steps_lat    <= '0;
            step_cnt     <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            mem_lock     <= 1'b0;
            net_rst      <= 1'b0;
            spike_gen_en <= 1'b0;
        end else begin
            state <= state_next;

            // Phase counter restarts on every state change.
            if ((state_next == state) && ((state == CLEAR) || (state == DRAIN))) begin
                phase_cnt <= phase_cnt + 1'b1;
            end else begin
                phase_cnt <= '0;
            end

            if (accept_start) begin
                steps_lat <= num_steps;
                step_cnt  <= '0;
                done      <= 1'b0;
            end else if (state_next == RUN) begin
                step_cnt <= step_cnt + 1'b1;
            end

            if (finish) begin
                done <= 1'b1;
            end

            // NOTE: outputs are decoded from the next state and registered,
            // so they change exactly with the state and never glitch.
            busy         <= (state_next != IDLE);
            mem_lock     <= (state_next != IDLE);
            net_rst      <= (state_next == CLEAR);
            spike_gen_en <= (state_next == RUN);
        end
    end

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
        spike_count_sat #(
            .WIDTH (COUNT_WIDTH)
        ) u_cnt (
            .clk   (S_AXI_ACLK),
            .rst_n (S_AXI_ARESETN),
            .clr   (accept_start),
            .en    (counting && spike_out[i]),
            .count (count_out[i*COUNT_WIDTH +: COUNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_snn_run_controller.sv
// Directed bench for snn_run_controller: a 16-bit counter instance and a
// 4-bit counter instance share all stimulus; expected run results are
// queued when a run is launched and compared when busy falls.
module tb_snn_run_controller;

    localparam int NO = 2;
    localparam int CW = 16;
    localparam int CWS = 4;
    localparam int SW = 16;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] num_steps = '0;
    logic [NO-1:0] spike_out = '0;

    logic             net_rst, spike_gen_en, mem_lock, busy, done;
    logic [SW-1:0]    step_cnt;
    logic [NO*CW-1:0] count_out;

    logic              net_rst_s, spike_gen_en_s, mem_lock_s, busy_s, done_s;
    logic [SW-1:0]     step_cnt_s;
    logic [NO*CWS-1:0] count_out_s;

    always #5 clk = ~clk;

    snn_run_controller #(
        .NUM_OUTPUTS(NO), .COUNT_WIDTH(CW), .STEP_WIDTH(SW), .SETTLE_CYCLES(SC)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
        .num_steps(num_steps), .spike_out(spike_out), .net_rst(net_rst),
        .spike_gen_en(spike_gen_en), .mem_lock(mem_lock), .busy(busy),
        .done(done), .step_cnt(step_cnt), .count_out(count_out)
    );

    snn_run_controller #(
        .NUM_OUTPUTS(NO), .COUNT_WIDTH(CWS), .STEP_WIDTH(SW), .SETTLE_CYCLES(SC)
    ) dut_sat (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
        .num_steps(num_steps), .spike_out(spike_out), .net_rst(net_rst_s),
        .spike_gen_en(spike_gen_en_s), .mem_lock(mem_lock_s), .busy(busy_s),
        .done(done_s), .step_cnt(step_cnt_s), .count_out(count_out_s)
    );

    typedef struct {
        int   busy_cyc;
        int   gen_cyc;
        int   rst_cyc;
        int   c0;
        int   c1;
        int   s0;
        int   s1;
        int   step;
        logic done;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int sat15(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    // abort_at: abort during this RUN cycle (1-based), 0 = none.
    // restart_at: re-issue start during this RUN cycle, 0 = none.
    task automatic run(input int steps, input logic [1:0] sp,
                       input int abort_at, input int restart_at);
        exp_t e, got;
        int   edges, busy_c, gen_c, rst_c, lock_c;
        bit   finished;
        if (abort_at == 0) begin
            e.busy_cyc = 2 * SC + steps;
            e.gen_cyc  = steps;
            e.step     = steps;
            e.done     = 1'b1;
            edges      = steps + SC;
        end else begin
            e.busy_cyc = SC + abort_at;
            e.gen_cyc  = abort_at;
            e.step     = abort_at;
            e.done     = 1'b0;
            edges      = abort_at - 1;
        end
        e.rst_cyc = SC;
        e.c0 = sp[0] ? edges : 0;
        e.c1 = sp[1] ? edges : 0;
        e.s0 = sat15(e.c0);
        e.s1 = sat15(e.c1);
        sb_q.push_back(e);

        @(negedge clk);
        num_steps = SW'(steps);
        spike_out = sp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("net_rst_on_start", {31'd0, net_rst}, 32'd1);
        check("done_cleared", {31'd0, done}, 32'd0);
        check("step_cleared", {16'd0, step_cnt}, 32'd0);

        busy_c = 0; gen_c = 0; rst_c = 0; lock_c = 0; finished = 1'b0;
        for (int g = 0; g < 300; g++) begin
            abort = 1'b0;
            start = 1'b0;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            busy_c++;
            if (spike_gen_en) gen_c++;
            if (net_rst) rst_c++;
            if (mem_lock) lock_c++;
            if (abort_at != 0 && spike_gen_en && gen_c == abort_at) abort = 1'b1;
            if (restart_at != 0 && spike_gen_en && gen_c == restart_at) begin
                start = 1'b1;
                num_steps = SW'(3);
            end
            @(negedge clk);
        end
        check("run_terminates", {31'd0, finished}, 32'd1);

        got = sb_q.pop_front();
        check("busy_cycles", busy_c, got.busy_cyc);
        check("mem_lock_cycles", lock_c, got.busy_cyc);
        check("spike_gen_cycles", gen_c, got.gen_cyc);
        check("net_rst_cycles", rst_c, got.rst_cyc);
        check("done_at_end", {31'd0, done}, {31'd0, got.done});
        check("step_cnt_at_end", {16'd0, step_cnt}, got.step);
        check("count0", {16'd0, count_out[0 +: CW]}, got.c0);
        check("count1", {16'd0, count_out[CW +: CW]}, got.c1);
        check("sat_count0", {28'd0, count_out_s[0 +: CWS]}, got.s0);
        check("sat_count1", {28'd0, count_out_s[CWS +: CWS]}, got.s1);
        check("gen_off_at_end", {31'd0, spike_gen_en}, 32'd0);
        check("net_rst_off_at_end", {31'd0, net_rst}, 32'd0);

        if (abort_at != 0) begin
            repeat (3) @(negedge clk);
            check("abort_count0_frozen", {16'd0, count_out[0 +: CW]}, got.c0);
            check("abort_count1_frozen", {16'd0, count_out[CW +: CW]}, got.c1);
            check("abort_step_frozen", {16'd0, step_cnt}, got.step);
            check("abort_stays_idle", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_mem_lock"}, {31'd0, mem_lock}, 32'd0);
        check({tag, "_net_rst"}, {31'd0, net_rst}, 32'd0);
        check({tag, "_gen_en"}, {31'd0, spike_gen_en}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_step"}, {16'd0, step_cnt}, 32'd0);
        check({tag, "_counts"}, count_out, 32'd0);
        check({tag, "_sat_counts"}, {24'd0, count_out_s}, 32'd0);
    endtask

    initial begin
        bit seen;

        // Reset state.
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Nominal run: 14 busy cycles, 10 RUN cycles, count0 = 12.
        run(10, 2'b01, 0, 0);

        // Zero steps: CLEAR then DRAIN only.
        run(0, 2'b00, 0, 0);

        // Saturation: the 4-bit instance holds at 15, the 16-bit one reaches 42.
        run(40, 2'b11, 0, 0);

        // Abort in the fifth RUN cycle.
        run(20, 2'b10, 5, 0);

        // Second start mid-run (with a different num_steps) is ignored.
        run(10, 2'b01, 0, 3);

        // start and abort together in IDLE: nothing starts, state untouched.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        num_steps = SW'(7);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", {31'd0, busy}, 32'd0);
        check("start_abort_net_rst", {31'd0, net_rst}, 32'd0);
        check("start_abort_done_kept", {31'd0, done}, 32'd1);
        check("start_abort_step_kept", {16'd0, step_cnt}, 32'd10);
        repeat (2) @(negedge clk);
        check("start_abort_still_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        num_steps = SW'(10);
        spike_out = 2'b01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int g = 0; g < 20; g++) begin
            if (spike_gen_en) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_run_before_reset", {31'd0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        check("mid_run_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh run after reset completes normally.
        run(10, 2'b01, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
